// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first through a single full-adder cell.
// Latency: result valid WIDTH cycles after operand acceptance; WIDTH+2 cycles minimum between operations.
// Backpressure: in_ready only while idle; a finished result is held stable until out_ready.

// Single-bit full adder cell, reused once per bit position.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,   state_d;
  logic [WIDTH-1:0] a_sh_q,    a_sh_d;
  logic [WIDTH-1:0] b_sh_q,    b_sh_d;
  logic [WIDTH-1:0] sum_sh_q,  sum_sh_d;
  logic [WIDTH-1:0] sum_out_q, sum_out_d;
  logic             carry_q,   carry_d;
  logic             cout_q,    cout_d;
  logic [CW-1:0]    cnt_q,     cnt_d;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_shift;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  // Written as shift/OR so it stays legal when WIDTH is 1.
  assign sum_shift = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  // Handshake flags depend only on the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum_out   = sum_out_q;
  assign cout_out  = cout_q;

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    sum_out_d = sum_out_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          carry_d = cin_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_shift;
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Publish the result only once every bit is done; outputs then hold until the next one.
          sum_out_d = sum_shift;
          cout_d    = fa_cout;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight and clears the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_sh_q  <= '0;
      sum_out_q <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      sum_sh_q  <= sum_sh_d;
      sum_out_q <= sum_out_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder that reuses the single-bit `full_adder` cell across `WIDTH` cycles to add two `WIDTH`-bit operands LSB-first. It sits directly around the `full_adder` stage. It feeds the cell's `a`, `b` and `cin` from operand shift registers and a carry flop, and consumes `s` and `cout` every cycle. Operands enter and results leave through valid/ready handshakes, so the block trades throughput for one full-adder's worth of logic.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range is `WIDTH >= 1`.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset; asynchronous, active-low.
- `in_valid` input, 1 bit: operands on `a_in`, `b_in`, `cin_in` are valid.
- `in_ready` output, 1 bit: block can accept operands; high only in IDLE.
- `a_in` input, `WIDTH` bits: operand A.
- `b_in` input, `WIDTH` bits: operand B.
- `cin_in` input, 1 bit: carry-in of the operation.
- `out_valid` output, 1 bit: `sum_out` and `cout_out` hold a completed result.
- `out_ready` input, 1 bit: downstream accepts the result.
- `sum_out` output, `WIDTH` bits: (A + B + cin) mod 2^`WIDTH`.
- `cout_out` output, 1 bit: carry-out of bit `WIDTH-1`.

## Operation
- Internal state:
  - `full_adder` instance with `a` = `a_sh[0]`, `b` = `b_sh[0]`, `cin` = `carry`.
  - Shift registers `a_sh`, `b_sh` and `sum_sh`, each `WIDTH` bits.
  - `carry` flop.
  - Bit counter `cnt`, width max(1, clog2(`WIDTH`)).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`: `a_sh` <= `a_in`, `b_sh` <= `b_in`, `carry` <= `cin_in`, `cnt` <= 0, go to RUN.
  - `in_valid` low: stay in IDLE.
- RUN, every cycle:
  - `a_sh` and `b_sh` shift right by one.
  - `sum_sh` <= {`s`, `sum_sh[WIDTH-1:1]`}.
  - `carry` <= `cout`.
  - `cnt` <= `cnt` + 1.
  - When `cnt == WIDTH-1`, go to DONE.
  - `in_valid` is ignored.
- DONE:
  - `out_valid` = 1.
  - `sum_out` = `sum_sh`, `cout_out` = `carry`.
  - On `out_valid && out_ready`, go to IDLE.
  - `in_valid` is ignored.
- `sum_out` and `cout_out` are registered.
  - They update only at the RUN-to-DONE transition.
  - They hold their values through DONE and the following IDLE, until the next result is produced.
- Only one operation is in flight at a time; there is no input buffering.

## Timing
- Reset, asynchronous on `rst_n` low, at any time including mid-RUN or in DONE:
  - The current operation is aborted; no partial result is ever presented.
  - State = IDLE, so `in_ready` = 1 immediately.
  - `out_valid` = 0, `sum_out` = 0, `cout_out` = 0.
  - `carry` = 0, `cnt` = 0, all shift registers = 0.
- `in_ready` and `out_valid` are decoded directly from the state register, with no combinational path from `in_valid` or `out_ready`.
- Latency: let E0 be the edge that accepts operands.
  - Bits 0..`WIDTH-1` are processed on edges E1..E`WIDTH`.
  - `out_valid` is high from just after E`WIDTH`.
  - For `WIDTH` = 1, `out_valid` is high after E1.
- Backpressure: with `out_ready` low, DONE holds indefinitely; `sum_out`, `cout_out` and `out_valid` stay stable.
- Release: on the edge where `out_valid && out_ready`, state becomes IDLE, so `in_ready` = 1 in the next cycle.
- Minimum period between accepted operations is `WIDTH` + 2 cycles: 1 IDLE + `WIDTH` RUN + 1 DONE.
- Carry chain: `carry` after the final RUN edge equals the arithmetic carry-out of the `WIDTH`-bit sum plus `cin_in`. `cout_out` must equal bit `WIDTH` of A + B + cin.

## Test plan
- `WIDTH`=8, A=0x5A, B=0x3C, cin=0 -> after 8 edges from acceptance, `out_valid`=1, `sum_out`=0x96, `cout_out`=0.
- A=0xFF, B=0x01, cin=0 -> `sum_out`=0x00, `cout_out`=1; A=0xFF, B=0xFF, cin=1 -> `sum_out`=0xFF, `cout_out`=1.
- Result 0x96 with `out_ready` held low 5 cycles and `in_valid` pulsed during RUN and DONE:
  - `out_valid`, `sum_out` and `cout_out` stay stable throughout; `in_ready` stays 0.
  - The extra operands are not captured.
  - After `out_ready`=1, `in_ready`=1 on the next cycle.
- `rst_n` asserted after 3 RUN edges of 0xFF+0x01:
  - Immediately `out_valid`=0, `in_ready`=1, `sum_out`=0x00, `cout_out`=0.
  - A following 0x10+0x20, cin=0 -> `sum_out`=0x30, `cout_out`=0.
- `WIDTH`=1, A=1, B=1, cin=1 -> one edge after acceptance, `sum_out`=1, `cout_out`=1. Back-to-back ops with `out_ready` tied high complete every 3 cycles.
- 1000 random operands with random `in_valid`/`out_ready` gaps, `WIDTH`=8 and 13 -> every result matches a reference A+B+cin model, in order, with no loss or duplication.
